kernel_onchip_memory_dp: RTL
============================

Name: kernel_onchip_memory_dp

Overview:
- Parametrised, true-dual-port on-chip RAM with two independent Avalon-MM slave ports, s1 and s2, on one clock.
- Successor to the single-port kernel on-chip memory. Adds:
  - configurable width and depth;
  - selectable read latency with readdatavalid;
  - waitrequest flow control;
  - an optional zero-fill (clear) engine after reset;
  - a defined write-collision policy between the two ports.
- Sits on the Nios II data/instruction interconnect as tightly shared program/data memory.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- BE_WIDTH, DATA_WIDTH/8: byteenable width.
- DEPTH, 20230: number of words.
- ADDR_WIDTH, 15: address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- READ_LATENCY, 1: cycles from read accept to readdatavalid; legal values 1 or 2 (2 adds an output register).
- CLEAR_ON_RESET, 0: when 1, the clear engine writes zero to every word after reset.
- INIT_FILE, "kernel_onchip_memory2.hex": initial contents; ignored when CLEAR_ON_RESET=1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- reset_req  in  1  when high, freezes the RAM clock enable; held contents are preserved.
- clken  in  1  global clock enable.
- s1_address  in  ADDR_WIDTH  port 1 word address.
- s1_chipselect  in  1  port 1 select.
- s1_read  in  1  port 1 read request.
- s1_write  in  1  port 1 write request.
- s1_byteenable  in  BE_WIDTH  port 1 byte lanes.
- s1_writedata  in  DATA_WIDTH  port 1 write data.
- s1_readdata  out  DATA_WIDTH  port 1 read data.
- s1_readdatavalid  out  1  port 1 read data valid.
- s1_waitrequest  out  1  port 1 stall.
- s2_*  (same set as s1_*)  port 2, identical semantics.

Behaviour:
- Clock/reset: everything is on clk. Reset is synchronous, active-high. RAM contents are not altered by reset itself.
- Reset values: s*_readdata = 0, s*_readdatavalid = 0, read-latency pipeline cleared.
  - s*_waitrequest = 1 while reset is high.
  - s*_waitrequest = 1 during clearing when CLEAR_ON_RESET=1.
  - Otherwise s*_waitrequest = 0 from the first cycle after reset.
- Enable: en = clken & ~reset_req.
  - When en = 0: both waitrequests are 1, nothing is accepted, and the read pipeline, readdata and readdatavalid hold their values.
- Accept condition per port: accept = chipselect & (read | write) & ~waitrequest.
  - read and write high together: treated as a write, with no readdatavalid.
- Write: the bytes selected by byteenable are updated at the accept edge; unselected bytes are unchanged.
- Read:
  - READ_LATENCY=1: readdata and readdatavalid are valid in the cycle after accept.
  - READ_LATENCY=2: they are valid two cycles after accept.
  - Fully pipelined: one read may be accepted per cycle per port.
  - readdatavalid is a single-cycle pulse per read.
  - readdata holds its last value while readdatavalid = 0.
- Out of range (address >= DEPTH): writes are discarded; reads return all zeros, with readdatavalid asserted normally.
- Read-during-write, same port: a write never returns data.
- Read-during-write, mixed ports (one port reads an address the other writes in the same cycle): the read returns the old data.
- Write collision (both ports write the same address in the same cycle):
  - s1's bytes win for every lane s1 enables;
  - s2's bytes land only in lanes s1 does not enable.
- Clear engine (CLEAR_ON_RESET=1), FSM IDLE -> CLEAR -> READY:
  - On the cycle reset deasserts: enter CLEAR, counter = 0.
  - Each en cycle: write 0 to address counter, then counter += 1.
  - When counter = DEPTH-1 is written: go to READY; waitrequest drops on the next cycle. This takes DEPTH cycles when en stays 1.
  - en = 0 pauses the counter.
  - Reset mid-clear returns to IDLE, then restarts at address 0.
- Clear engine (CLEAR_ON_RESET=0): the FSM stays in READY.

Test Plan:
- Byte-lane write: s1 write addr 5 = 0xAABBCCDD, then s1 write addr 5 = 0x11223344 with byteenable 0b0101, then read with READ_LATENCY=1 -> readdata 0xAA22CC44, readdatavalid exactly 1 cycle after accept.
- Pipelined reads: READ_LATENCY=2, back-to-back s2 reads of addr 0..3 holding 0,1,2,3 -> readdatavalid high for 4 consecutive cycles starting 2 cycles after the first accept, data 0,1,2,3.
- Collision: same cycle, s1 writes addr 7 = 0xFFFFFFFF with be 0b0011 and s2 writes addr 7 = 0x12345678 with be 0b1111 -> addr 7 reads 0x1234FFFF.
- Mixed-port read-during-write: addr 9 = 0x1; s1 writes 0x2 while s2 reads addr 9 in the same cycle -> s2 gets 0x1; a later read gets 0x2.
- Clear engine: CLEAR_ON_RESET=1, DEPTH=16, preload nonzero:
  - reset 1 cycle -> waitrequest high for exactly 16 cycles after reset release, then all 16 words read 0;
  - reassert reset at clear cycle 8 -> clear restarts and takes another 16 cycles.
- Stall and range:
  - clken = 0 for 3 cycles during a pending READ_LATENCY=2 read -> waitrequest = 1 throughout, and readdatavalid is delayed by exactly 3 cycles.
  - Read of addr DEPTH -> readdata 0 with readdatavalid = 1.
  - Write of addr DEPTH -> no word changes.

Source files
------------

// File: rtl/kernel_onchip_memory_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM slave ports on one clock.
// Selectable read latency (1 or 2) and an optional zero-fill engine that runs after reset.
module kernel_onchip_memory_dp #(
    parameter int DATA_WIDTH     = 32,
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int DEPTH          = 20230,
    parameter int ADDR_WIDTH     = 15,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 0,
    parameter     INIT_FILE      = "kernel_onchip_memory2.hex"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reset_req,
    input  logic                  clken,
    input  logic [ADDR_WIDTH-1:0] s1_address,
    input  logic                  s1_chipselect,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [BE_WIDTH-1:0]   s1_byteenable,
    input  logic [DATA_WIDTH-1:0] s1_writedata,
    output logic [DATA_WIDTH-1:0] s1_readdata,
    output logic                  s1_readdatavalid,
    output logic                  s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0] s2_address,
    input  logic                  s2_chipselect,
    input  logic                  s2_read,
    input  logic                  s2_write,
    input  logic [BE_WIDTH-1:0]   s2_byteenable,
    input  logic [DATA_WIDTH-1:0] s2_writedata,
    output logic [DATA_WIDTH-1:0] s2_readdata,
    output logic                  s2_readdatavalid,
    output logic                  s2_waitrequest
);
    // state  | meaning
    // IDLE   | reset seen, zero-fill pending; fills address 0 on the first enabled cycle
    // CLEAR  | writing zero to address clr_cnt once per enabled cycle
    // READY  | fill done (or disabled); both ports accept transfers

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_READY} state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      clr_cnt;
    logic                  en, stall, clearing, clr_we, clr_last;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Port signals gathered into arrays, index 0 = s1, index 1 = s2
    logic [ADDR_WIDTH-1:0] p_addr  [2];
    logic [BE_WIDTH-1:0]   p_be    [2];
    logic [DATA_WIDTH-1:0] p_wdata [2];
    logic [1:0]            p_cs, p_rd, p_wen;
    logic [1:0]            in_rng, acc, we, re;
    logic [IDX_W-1:0]      idx     [2];
    logic [DATA_WIDTH-1:0] rd_word [2];
    logic [DATA_WIDTH-1:0] stage_q [2];
    logic [DATA_WIDTH-1:0] rdata_q [2];
    logic [1:0]            stage_v, rvalid_q;

    assign p_addr[0]  = s1_address;
    assign p_addr[1]  = s2_address;
    assign p_be[0]    = s1_byteenable;
    assign p_be[1]    = s2_byteenable;
    assign p_wdata[0] = s1_writedata;
    assign p_wdata[1] = s2_writedata;
    assign p_cs       = {s2_chipselect, s1_chipselect};
    assign p_rd       = {s2_read, s1_read};
    assign p_wen      = {s2_write, s1_write};

    assign en       = clken & ~reset_req;
    assign clr_last = (clr_cnt == IDX_W'(DEPTH - 1));
    assign stall    = reset | ~en | clearing;

    always_ff @(posedge clk) begin
        if (reset) state <= (CLEAR_ON_RESET != 0) ? ST_IDLE : ST_READY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (en) state_nxt = clr_last ? ST_READY : ST_CLEAR;
            ST_CLEAR: if (en && clr_last) state_nxt = ST_READY;
            default:  state_nxt = state;
        endcase
    end

    // Reset itself must never touch the array, so fill writes are gated by it
    always_comb begin
        clearing = (state != ST_READY);
        clr_we   = clearing & en & ~reset;
    end

    always_ff @(posedge clk) begin
        if (reset)       clr_cnt <= '0;
        else if (clr_we) clr_cnt <= clr_cnt + IDX_W'(1);
    end

    always_comb begin
        in_rng = '0;
        acc    = '0;
        we     = '0;
        re     = '0;
        for (int p = 0; p < 2; p++) begin
            idx[p]     = p_addr[p][IDX_W-1:0];
            in_rng[p]  = 32'(p_addr[p]) < 32'(DEPTH);
            acc[p]     = p_cs[p] & (p_rd[p] | p_wen[p]) & ~stall;
            we[p]      = acc[p] & p_wen[p] & in_rng[p];
            re[p]      = acc[p] & ~p_wen[p];
            rd_word[p] = in_rng[p] ? mem[idx[p]] : '0;
        end
    end

    // s2 is applied first so s1's lanes overwrite it on a same-address collision
    always_ff @(posedge clk) begin
        if (clr_we) mem[clr_cnt] <= '0;
        for (int p = 1; p >= 0; p--) begin
            if (we[p]) begin
                for (int b = 0; b < BE_WIDTH; b++) begin
                    if (p_be[p][b]) mem[idx[p]][8*b +: 8] <= p_wdata[p][8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_v  <= '0;
            rvalid_q <= '0;
            for (int p = 0; p < 2; p++) begin
                stage_q[p] <= '0;
                rdata_q[p] <= '0;
            end
        end else if (en) begin
            for (int p = 0; p < 2; p++) begin
                stage_v[p] <= re[p];
                if (re[p]) stage_q[p] <= rd_word[p];
                if (READ_LATENCY == 2) begin
                    rvalid_q[p] <= stage_v[p];
                    if (stage_v[p]) rdata_q[p] <= stage_q[p];
                end else begin
                    rvalid_q[p] <= re[p];
                    if (re[p]) rdata_q[p] <= rd_word[p];
                end
            end
        end
    end

    assign s1_readdata      = rdata_q[0];
    assign s2_readdata      = rdata_q[1];
    assign s1_readdatavalid = rvalid_q[0];
    assign s2_readdatavalid = rvalid_q[1];
    assign s1_waitrequest   = stall;
    assign s2_waitrequest   = stall;

endmodule
